// File: rtl/pe256_scalable.sv
// 256-input highest-index priority encoder, split into a 16x16 array: the top
// non-empty row is chosen first, then the top set bit inside that row.

module pe256_pe16 (
  input  logic [15:0] in,
  output logic [3:0]  idx,
  output logic        any
);
  // Ascending scan, so the last set bit seen (the highest index) wins.
  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (in[i]) idx = 4'(i);
    end
    any = |in;
  end
endmodule

module pe256_mux16 (
  input  logic [255:0] rows,
  input  logic [3:0]   sel,
  output logic [15:0]  out
);
  assign out = rows[{sel, 4'b0000} +: 16];
endmodule

module pe256_scalable (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] d,
  output logic [7:0]   q,
  output logic         v
);
  logic [15:0] row_valid;
  logic [3:0]  row_idx;
  logic        row_any;
  logic [15:0] sel_row;
  logic [3:0]  col_idx;
  logic        col_any;
  logic [7:0]  q_d, q_q;
  logic        v_d, v_q;

  always_comb begin
    row_valid = 16'd0;
    for (int r = 0; r < 16; r++) begin
      row_valid[r] = |d[16*r +: 16];
    end
  end

  pe256_pe16 u_row_enc (
    .in  (row_valid),
    .idx (row_idx),
    .any (row_any)
  );

  pe256_mux16 u_row_mux (
    .rows (d),
    .sel  (row_idx),
    .out  (sel_row)
  );

  pe256_pe16 u_col_enc (
    .in  (sel_row),
    .idx (col_idx),
    .any (col_any)
  );

  // An empty vector yields index 0; v is what tells it apart from bit 0.
  always_comb begin
    q_d = row_any ? {row_idx, col_idx} : 8'd0;
    v_d = row_any & col_any;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 8'd0;
      v_q <= 1'b0;
    end else begin
      q_q <= q_d;
      v_q <= v_d;
    end
  end

  assign q = q_q;
  assign v = v_q;
endmodule

// File: tb/tb_pe256_scalable.sv
// Bench for pe256_scalable: the driver pushes the expected {v,q} for every
// sampling edge; the monitor pops and compares one entry just after each edge.

module tb_pe256_scalable;
  logic         clk;
  logic         rst;
  logic [255:0] d;
  logic [7:0]   q;
  logic         v;

  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int vec_no   = 0;

  pe256_scalable dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q),
    .v   (v)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [8:0] ref_enc(input logic [255:0] x);
    for (int i = 255; i >= 0; i--) begin
      if (x[i]) return {1'b1, 8'(i)};
    end
    return 9'd0;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic [255:0] dv, input logic [8:0] e);
    @(negedge clk);
    rst = r;
    d   = dv;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [8:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({v, q} === e) begin
        n_pass++;
      end else begin
        $display("FAIL vec%0d got v=%b q=%0d expected v=%b q=%0d",
                 vec_no, v, q, e[8], e[7:0]);
      end
      vec_no++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] x;
    int waited;
    rst = 1'b1;
    d   = '0;

    // reset with all ones present, then release with zero input
    drive(1'b1, '1, 9'd0);
    drive(1'b1, '1, 9'd0);
    drive(1'b0, '0, 9'd0);

    // walking one
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 256'd1 << i, {1'b1, 8'(i)});
    end

    // multi-bit
    x = '0; x[5] = 1'b1; x[123] = 1'b1; x[200] = 1'b1;
    drive(1'b0, x, {1'b1, 8'd200});
    drive(1'b0, '1, {1'b1, 8'd255});
    x = '0; x[0] = 1'b1; x[16] = 1'b1;
    drive(1'b0, x, {1'b1, 8'd16});

    // back-to-back changes
    drive(1'b0, 256'd1 << 3,   {1'b1, 8'd3});
    drive(1'b0, 256'd1 << 250, {1'b1, 8'd250});
    drive(1'b0, '0,            9'd0);
    drive(1'b0, 256'd1 << 128, {1'b1, 8'd128});

    // random vectors, shifted down by random amounts so winners spread over rows
    for (int k = 0; k < 30; k++) begin
      for (int w = 0; w < 8; w++) x[32*w +: 32] = $urandom;
      x = x >> $urandom_range(0, 255);
      if (k % 5 == 0) x = x & (x >> $urandom_range(1, 7));
      drive(1'b0, x, ref_enc(x));
    end

    // reset in the middle of a stream
    drive(1'b0, 256'd1 << 77, {1'b1, 8'd77});
    drive(1'b0, 256'd1 << 77, {1'b1, 8'd77});
    drive(1'b1, 256'd1 << 77, 9'd0);
    drive(1'b0, 256'd1 << 77, {1'b1, 8'd77});

    // drain, bounded
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain left=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pe256_scalable.md
# pe256_scalable

256-input highest-index priority encoder with registered outputs, built as a 16×16 array (1D-to-2D conversion) with a multiplexer selecting the winning row. It reports the index of the most significant set bit of a 256-bit request vector plus a valid flag. It serves as the scalable arbitration/leading-one-detect stage of the datapath, feeding an 8-bit index to downstream logic one clock after sampling.

## Interface
- No parameters; width is fixed at 256 inputs / 8-bit index.
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  synchronous, active-high reset.
- d  input  256  request vector; bit i set means request i active.
- q  output  8  index of the highest set bit of d (registered).
- v  output  1  high when at least one bit of d is set (registered).

## Operation
- Priority: the highest index wins. If d[i]=1 and d[j]=0 for all j>i, then q=i.
- 2D decomposition, combinational, between sampling and register:
  - Rows r=0..15: row_r = d[16r+15 : 16r]; row_valid[r] = OR of row_r.
  - Row encoder: 16-input highest-index priority encoder on row_valid gives row index R (4 bits) and any-valid.
  - Row mux: 16:1 mux of 16-bit rows selected by R gives sel_row = row_R.
  - Column encoder: 16-input highest-index priority encoder on sel_row gives C (4 bits).
  - Result: q_next = {R, C} (= 16R + C); v_next = OR of row_valid.
- The 16-input encoder is a reusable submodule instantiated twice; the 16:1 mux is a submodule.
- All-zero input: q_next = 8'd0, v_next = 0. q=0 with v=1 means bit 0 is the winner; consumers must qualify q with v.
- Lower-priority set bits never affect q (e.g. bits 5, 123, 200 set -> q=200).
- No handshake or backpressure: a new d may be presented every cycle and a result is produced every cycle.

## Timing
- Latency: 1 cycle. d sampled at rising edge k; q/v reflect that d from just after edge k until edge k+1.
- Throughput: one result per clock, fully pipelined (single register stage on q and v only; d is not registered internally).
- Reset: if rst=1 at a rising edge, q <= 8'd0 and v <= 0 regardless of d. Reset takes priority over the new result.
- Deasserting rst: the first edge with rst=0 loads the encode of d present at that edge.
- Reset mid-stream: the pending result is discarded; no state other than q/v exists.
- Before the first reset, q/v are undefined (X in simulation).
- Combinational path d -> register is the row-OR, 16-input encoder, 16:1 mux, 16-input encoder chain; it must close at the target clock without extra stages.

## Test plan
- Reset: rst=1 for 2 edges with d=all ones -> q=0, v=0; release with d=0 -> after next edge q=0, v=0.
- Walking one: for i=0..255, d=1<<i held one edge -> q=i, v=1 (covers every row/column, including i=0, 15, 16, 255).
- Multi-bit: d bits {5,123,200} set -> q=200, v=1; d=all ones -> q=255; d bits {0,16} -> q=16.
- Back-to-back: change d every cycle (1<<3, 1<<250, 0, 1<<128) -> q sequence 3, 250, 0(v=0), 128, each exactly one cycle after its input.
- Random: ≥20 random 256-bit vectors compared against a reference model (scan from bit 255 down, first set bit; 0/v=0 if none).
- Reset mid-stream: assert rst while d=1<<77 streaming -> q=0, v=0 at that edge; deassert -> q=77 one edge later.
